// File: rtl/stream_to_onchip_mem_writer.sv
// Packs an 8-bit valid/ready byte stream little-endian into 32-bit words and
// writes them to on-chip memory, starting at a programmed base word address.
module stream_to_onchip_mem_writer #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  ONE_LEN  = LEN_W'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [ADDR_W-1:0] offset, offset_nx;
  logic [LEN_W-1:0]  remaining, remaining_nx;
  logic [1:0]        idx, idx_nx;
  logic [31:0]       lanes, lanes_nx;
  logic [3:0]        be, be_nx;

  assign in_ready = (state == FILL);

  always_comb begin
    state_nx     = state;
    base_nx      = base;
    offset_nx    = offset;
    remaining_nx = remaining;
    idx_nx       = idx;
    lanes_nx     = lanes;
    be_nx        = be;
    case (state)
      IDLE: begin
        if (start) begin
          base_nx      = base_addr;
          remaining_nx = byte_count;
          offset_nx    = '0;
          idx_nx       = '0;
          lanes_nx     = '0;
          be_nx        = '0;
          state_nx     = (byte_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        // The fourth lane or the last byte of the transfer closes the word.
        if (in_valid) begin
          lanes_nx[{idx, 3'b000} +: 8] = in_data;
          be_nx[idx]                   = 1'b1;
          idx_nx                       = idx + 2'd1;
          remaining_nx                 = remaining - ONE_LEN;
          if (idx == 2'd3 || remaining == ONE_LEN) state_nx = WRITE;
        end
      end
      WRITE: begin
        offset_nx = offset + ONE_ADDR;
        lanes_nx  = '0;
        be_nx     = '0;
        idx_nx    = '0;
        state_nx  = (remaining == '0) ? DONE : FILL;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write outputs are loaded on entry to WRITE so they are valid during it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      base           <= '0;
      offset         <= '0;
      remaining      <= '0;
      idx            <= '0;
      lanes          <= '0;
      be             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_write      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      state          <= state_nx;
      base           <= base_nx;
      offset         <= offset_nx;
      remaining      <= remaining_nx;
      idx            <= idx_nx;
      lanes          <= lanes_nx;
      be             <= be_nx;
      busy           <= (state_nx != IDLE);
      done           <= (state_nx == DONE);
      avm_write      <= (state_nx == WRITE);
      avm_chipselect <= (state_nx == WRITE);
      if (state_nx == WRITE) begin
        avm_address    <= base + offset;
        avm_byteenable <= be_nx;
        avm_writedata  <= lanes_nx;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_onchip_mem_writer.sv
// Directed, table-driven bench for stream_to_onchip_mem_writer: expected memory
// writes per transfer are listed by hand and compared against a write monitor.
module tb_stream_to_onchip_mem_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [13:0] base_addr;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [13:0] base;
    logic [15:0] count;
    logic [7:0]  first;
    logic [7:0]  step;
    bit          gaps;
    int          n_wr;
    logic [13:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  b0, b1;
  } case_t;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t wq[$];
  int  done_cnt  = 0;
  int  ready_cnt = 0;

  stream_to_onchip_mem_writer #(.ADDR_W(14), .LEN_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .byte_count     (byte_count),
    .busy           (busy),
    .done           (done),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: record every write, done pulse and in_ready cycle.
  always @(negedge clk) begin
    if (avm_write === 1'b1) wq.push_back('{a: avm_address, d: avm_writedata, b: avm_byteenable});
    if (done === 1'b1) done_cnt++;
    if (in_ready === 1'b1) ready_cnt++;
    if (avm_chipselect !== avm_write) begin
      checks++;
      failures++;
      $display("[TB] FAIL chipselect_eq_write actual=%b required=%b", avm_chipselect, avm_write);
    end
  end

  task automatic apply_stimulus(input case_t c, input string tag);
    int          i;
    int          cyc;
    logic        v;
    logic        acc;
    logic [3:0]  gap_pat;
    logic [7:0]  b;
    gap_pat = 4'b1001;
    wq.delete();
    done_cnt  = 0;
    ready_cnt = 0;
    start      = 1'b1;
    base_addr  = c.base;
    byte_count = c.count;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 14'h1555;
    byte_count = 16'h0007;
    check_output({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    if (c.count == 16'd0) begin
      check_output({tag, "_zero_done"}, 32'(done), 32'd1);
    end else begin
      i   = 0;
      cyc = 0;
      while (i < int'(c.count) && cyc < 200) begin
        v = c.gaps ? gap_pat[cyc % 4] : 1'b1;
        b = c.first + c.step * 8'(i);
        in_valid = v;
        in_data  = b;
        if (c.gaps && cyc == 3) begin
          start      = 1'b1;
          base_addr  = 14'h0AAA;
          byte_count = 16'd2;
        end else begin
          start = 1'b0;
        end
        acc = v && in_ready;
        @(posedge clk); #1;
        if (acc) i++;
        cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < int'(c.count)) check_output({tag, "_stream_timeout"}, 32'(i), 32'(c.count));
      check_output({tag, "_lat_write"}, 32'(avm_write), 32'd1);
      @(posedge clk); #1;
      check_output({tag, "_lat_done"}, 32'(done), 32'd1);
    end
    @(posedge clk); #1;
    check_output({tag, "_busy_low_after"}, 32'(busy), 32'd0);
    check_output({tag, "_done_low_after"}, 32'(done), 32'd0);
    check_output({tag, "_n_writes"}, 32'(wq.size()), 32'(c.n_wr));
    check_output({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (c.count == 16'd0) check_output({tag, "_zero_ready"}, 32'(ready_cnt), 32'd0);
    if (c.n_wr >= 1 && wq.size() >= 1) begin
      check_output({tag, "_w0_addr"}, 32'(wq[0].a), 32'(c.a0));
      check_output({tag, "_w0_data"}, wq[0].d, c.d0);
      check_output({tag, "_w0_be"}, 32'(wq[0].b), 32'(c.b0));
    end
    if (c.n_wr >= 2 && wq.size() >= 2) begin
      check_output({tag, "_w1_addr"}, 32'(wq[1].a), 32'(c.a1));
      check_output({tag, "_w1_data"}, wq[1].d, c.d1);
      check_output({tag, "_w1_be"}, 32'(wq[1].b), 32'(c.b1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_output({tag, "_write"}, 32'(avm_write), 32'd0);
    check_output({tag, "_chipselect"}, 32'(avm_chipselect), 32'd0);
    check_output({tag, "_address"}, 32'(avm_address), 32'd0);
    check_output({tag, "_byteenable"}, 32'(avm_byteenable), 32'd0);
    check_output({tag, "_writedata"}, avm_writedata, 32'd0);
  endtask

  case_t cases[7];
  case_t tail_case;

  initial begin
    int acc_cnt;
    int cyc;
    logic acc;

    cases[0] = '{14'h0100, 16'd8, 8'h11, 8'h11, 1'b0, 2, 14'h0100, 14'h0101, 32'h44332211, 32'h88776655, 4'hF, 4'hF};
    cases[1] = '{14'h0020, 16'd6, 8'hA1, 8'h01, 1'b0, 2, 14'h0020, 14'h0021, 32'hA4A3A2A1, 32'h0000A6A5, 4'hF, 4'h3};
    cases[2] = '{14'h0055, 16'd0, 8'h00, 8'h00, 1'b0, 0, 14'h0000, 14'h0000, 32'h0, 32'h0, 4'h0, 4'h0};
    cases[3] = '{14'h3FFF, 16'd8, 8'h11, 8'h11, 1'b0, 2, 14'h3FFF, 14'h0000, 32'h44332211, 32'h88776655, 4'hF, 4'hF};
    cases[4] = '{14'h0100, 16'd8, 8'h11, 8'h11, 1'b1, 2, 14'h0100, 14'h0101, 32'h44332211, 32'h88776655, 4'hF, 4'hF};
    cases[5] = '{14'h0200, 16'd3, 8'h01, 8'h01, 1'b0, 1, 14'h0200, 14'h0000, 32'h00030201, 32'h0, 4'h7, 4'h0};
    cases[6] = '{14'h0300, 16'd5, 8'h10, 8'h10, 1'b0, 2, 14'h0300, 14'h0301, 32'h40302010, 32'h00000050, 4'hF, 4'h1};
    tail_case = '{14'h0040, 16'd4, 8'hC1, 8'h01, 1'b0, 1, 14'h0040, 14'h0000, 32'hC4C3C2C1, 32'h0, 4'hF, 4'h0};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    byte_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) apply_stimulus(cases[k], $sformatf("case%0d", k));

    // Reset after 5 of 8 bytes: transfer is abandoned.
    wq.delete();
    done_cnt   = 0;
    start      = 1'b1;
    base_addr  = 14'h0100;
    byte_count = 16'd8;
    @(posedge clk); #1;
    start   = 1'b0;
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < 5 && cyc < 50) begin
      in_valid = 1'b1;
      in_data  = 8'h11 * 8'(acc_cnt + 1);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) acc_cnt++;
      cyc++;
    end
    in_valid = 1'b0;
    check_output("rst_mid_bytes_sent", 32'(acc_cnt), 32'd5);
    check_output("rst_mid_writes_before", 32'(wq.size()), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    reset_n = 1'b1;
    wq.delete();
    done_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check_output("rst_mid_no_writes", 32'(wq.size()), 32'd0);
    check_output("rst_mid_no_done", 32'(done_cnt), 32'd0);
    apply_stimulus(tail_case, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stream_to_onchip_mem_writer.md
Name: stream_to_onchip_mem_writer

Overview:
- Upstream write master for the 16K x 32 single-port on-chip memory (14-bit word address, 4-bit byteenable, one-cycle writes, no waitrequest).
- Accepts an 8-bit valid/ready byte stream and packs it little-endian into 32-bit words.
- Issues one memory write per word, starting at a programmed base word address, for a programmed byte count; partial final words are written with a reduced byteenable.
- Signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 14, memory word-address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, width of the byte_count input.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on an accepted start
- byte_count  in  LEN_W  number of bytes to transfer; latched on an accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  block accepts a byte when in_valid & in_ready
- avm_address  out  ADDR_W  memory word address
- avm_byteenable  out  4  lane enables; bit n enables writedata[8n+7:8n]
- avm_chipselect  out  1  equals avm_write
- avm_write  out  1  write strobe, exactly one cycle per word
- avm_writedata  out  32  packed word

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE. busy, done, in_ready, avm_write and avm_chipselect are 0. avm_address, avm_byteenable, avm_writedata, the lane index, the word offset and the remaining count are all 0. Reset mid-transfer abandons the transfer: no further writes, no done pulse.
- All outputs are registered except in_ready, which is decoded from state (1 only in FILL).
- States:
  - IDLE: if start=1, latch base_addr and byte_count, clear the word offset and lane index, then go to DONE if byte_count==0, else FILL.
  - FILL: on each accepted byte, store it in lane[idx], set be[idx]=1, increment idx and decrement remaining. If idx==3 or remaining becomes 0 on this acceptance, go to WRITE; no byte is accepted in that same transition cycle after the fourth lane. Gaps in in_valid simply hold the state.
  - WRITE: avm_write=avm_chipselect=1 for exactly this cycle, with avm_address=(base+offset) mod 2^ADDR_W, avm_writedata=packed lanes (unwritten lanes 0) and avm_byteenable=the accumulated mask. On exit: increment offset, clear lanes, mask and idx. Go to DONE if remaining==0, else FILL.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- start while busy is ignored; base_addr and byte_count changes during a transfer have no effect.
- Byte order: first byte of each word goes to writedata[7:0]; the fourth goes to [31:24].
- Partial final word: N leftover bytes (1..3) give byteenable 4'b0001, 4'b0011 or 4'b0111.
- Throughput: at most 4 bytes per 5 cycles (in_ready is low during WRITE).
- Latency: the last accepted byte is followed by WRITE on the next cycle and DONE on the cycle after.
- Number of writes = ceil(byte_count/4). Maximum byte_count = 2^LEN_W-1.

Test Plan:
- Full words: base=0x0100, count=8, bytes 11..88 streamed continuously -> two writes: 0x0100/0x44332211/be=F, then 0x0101/0x88776655/be=F; done one cycle after the second write; busy low the cycle after done.
- Partial tail: base=0x0020, count=6, bytes A1..A6 -> 0x0020/0xA4A3A2A1/be=F, then 0x0021/0x0000A6A5/be=0011; exactly 2 writes.
- Zero length: start with count=0 -> no avm_write, in_ready never high, done pulse in the cycle after start.
- Address wrap: base=0x3FFF, count=8 -> writes at 0x3FFF then 0x0000.
- Backpressure/ignore: in_valid toggled 1-0-0-1 pattern, plus a start pulse mid-transfer with different base -> data and addresses identical to the continuous case; the second start has no effect.
- Reset mid-transfer: reset_n low after 5 of 8 bytes -> all outputs 0 next cycle, no done pulse; a new start with count=4 then completes normally.
